fifo_read_ctrl: RTL and testbench

- Read-side controller for the dual-clock FIFO. Runs entirely in the read_clk domain.
- Owns the binary/Gray read pointer and drives read_address into the FIFO memory.
- Computes the empty flag from the write pointer, which arrives already synchronized into this domain.
- Converts the memory's 1-cycle registered read into a first-word-fall-through valid/ready stream using a 2-entry output buffer, so downstream back-pressure never loses or reorders data.

---
 rtl/fifo_read_ctrl.sv | 98 +++++++++
 tb/tb_fifo_read_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of a dual-clock FIFO: Gray read pointer, empty/level flags,
// and a 2-entry buffer turning the memory's registered read into a FWFT valid/ready stream.
module fifo_read_ctrl #(
  parameter int data_size    = 8,
  parameter int address_size = 4
) (
  input  logic                    read_clk,
  input  logic                    read_rst_n,
  input  logic [address_size:0]   write_ptr_sync,
  output logic [address_size-1:0] read_address,
  input  logic [data_size-1:0]    mem_read_data,
  output logic [address_size:0]   read_ptr,
  output logic                    read_empty,
  output logic [address_size:0]   read_level,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [data_size-1:0]    out_data
);

  localparam int ptr_w = address_size + 1;

  logic [ptr_w-1:0]     rbin;
  logic [ptr_w-1:0]     rbin_next;
  logic [ptr_w-1:0]     rgray_next;
  logic [ptr_w-1:0]     level_next;
  logic                 skid_valid;
  logic [data_size-1:0] skid_data;
  logic                 fetch_pend;
  logic [1:0]           held;
  logic                 pop;
  logic                 issue;

  function automatic logic [ptr_w-1:0] gray2bin(input logic [ptr_w-1:0] g);
    logic [ptr_w-1:0] b;
    b[ptr_w-1] = g[ptr_w-1];
    for (int i = ptr_w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    held       = 2'(out_valid) + 2'(skid_valid) + 2'(fetch_pend);
    pop        = out_valid && out_ready;
    // A full buffer may still issue when the head leaves this cycle: one out, one in.
    issue      = !read_empty && ((held < 2'd2) || (held == 2'd2 && pop));
    rbin_next  = rbin + ptr_w'(issue);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    level_next = gray2bin(write_ptr_sync) - rbin_next;
  end

  assign read_address = rbin[address_size-1:0];

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      rbin       <= '0;
      read_ptr   <= '0;
      read_empty <= 1'b1;
      read_level <= '0;
      fetch_pend <= 1'b0;
    end else begin
      rbin       <= rbin_next;
      read_ptr   <= rgray_next;
      read_empty <= (rgray_next == write_ptr_sync);
      read_level <= level_next;
      fetch_pend <= issue;
    end
  end

  // Skid word is older than the returning word, so it always reaches out_data first.
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid <= 1'b1;
        out_data  <= skid_data;
        if (fetch_pend) begin
          skid_data <= mem_read_data;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (fetch_pend) begin
        out_valid <= 1'b1;
        out_data  <= mem_read_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (fetch_pend) begin
      skid_valid <= 1'b1;
      skid_data  <= mem_read_data;
    end
  end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Self-checking bench for fifo_read_ctrl: a behavioural producer/memory and a word
// queue model check ordering, stalls, flags and pointers under random back-pressure.
module tb_fifo_read_ctrl;

  localparam int data_size    = 8;
  localparam int address_size = 4;
  localparam int depth        = 1 << address_size;
  localparam int ptr_w        = address_size + 1;

  logic                    read_clk = 1'b0;
  logic                    read_rst_n = 1'b0;
  logic [ptr_w-1:0]        write_ptr_sync = '0;
  logic [address_size-1:0] read_address;
  logic [data_size-1:0]    mem_read_data;
  logic [ptr_w-1:0]        read_ptr;
  logic                    read_empty;
  logic [ptr_w-1:0]        read_level;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [data_size-1:0]    out_data;

  fifo_read_ctrl #(.data_size(data_size), .address_size(address_size)) dut (
    .read_clk      (read_clk),
    .read_rst_n    (read_rst_n),
    .write_ptr_sync(write_ptr_sync),
    .read_address  (read_address),
    .mem_read_data (mem_read_data),
    .read_ptr      (read_ptr),
    .read_empty    (read_empty),
    .read_level    (read_level),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data)
  );

  always #5 read_clk = ~read_clk;

  // Behavioural FIFO memory with a one-cycle registered read port.
  logic [data_size-1:0] mem [depth];
  always @(posedge read_clk) mem_read_data <= mem[read_address];

  int                   n_checks = 0;
  int                   n_errors = 0;
  int                   wbin = 0;
  int                   consumed = 0;
  logic [data_size-1:0] exp_q[$];
  logic                 mon_en = 1'b0;
  logic                 stall_prev = 1'b0;
  logic [data_size-1:0] stall_data = '0;
  logic [ptr_w-1:0]     wps_q = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ptr_w-1:0] to_gray(input int b);
    logic [ptr_w-1:0] v;
    v = ptr_w'(b);
    return v ^ (v >> 1);
  endfunction

  function automatic int from_gray(input logic [ptr_w-1:0] g);
    int b;
    b = 0;
    for (int i = ptr_w - 1; i >= 0; i--) b = (b << 1) | (((b & 1) ^ int'(g[i])) & 1);
    return b;
  endfunction

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic push_word(input logic [data_size-1:0] d);
    mem[wbin % depth] = d;
    wbin++;
    exp_q.push_back(d);
    write_ptr_sync = to_gray(wbin);
  endtask

  task automatic do_reset();
    mon_en         = 1'b0;
    read_rst_n     = 1'b0;
    write_ptr_sync = '0;
    out_ready      = 1'b0;
    wbin           = 0;
    consumed       = 0;
    exp_q.delete();
    repeat (3) @(posedge read_clk);
    #1 read_rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  always @(posedge read_clk) wps_q = write_ptr_sync;

  // Cycle monitor: in-order delivery, stable data under stall, and the flag/pointer rules.
  always @(negedge read_clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(stall_data));
      end
      check("empty_rule", 32'(read_empty), 32'(read_ptr == wps_q));
      check("level_rule", 32'(read_level), (from_gray(wps_q) - from_gray(read_ptr)) & (2*depth-1));
      check("addr_rule", 32'(read_address), from_gray(read_ptr) % depth);
      if (out_valid && out_ready) begin
        check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("data_order", 32'(out_data), 32'(exp_q.pop_front()));
        consumed++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic run_random(input int words, input int ready_pct);
    int pushed;
    pushed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (pushed < words && (wbin - consumed) < depth && $urandom_range(0, 99) < 70) begin
        push_word(data_size'($urandom));
        pushed++;
      end
      out_ready = ($urandom_range(0, 99) < ready_pct);
      if (pushed == words && exp_q.size() == 0) break;
      tick();
    end
    check("random_complete", 32'(pushed == words && exp_q.size() == 0), 32'd1);
  endtask

  task automatic drain_and_check(input string tag);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) tick();
    check({tag, "_drained"}, exp_q.size(), 0);
    tick();
    tick();
    check({tag, "_empty"}, 32'(read_empty), 32'd1);
    check({tag, "_level"}, 32'(read_level), 32'd0);
    check({tag, "_ptr"}, 32'(read_ptr), 32'(to_gray(wbin)));
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < depth; i++) mem[i] = '0;

    // Reset state held for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("rst_empty", 32'(read_empty), 32'd1);
      check("rst_level", 32'(read_level), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ptr", 32'(read_ptr), 32'd0);
      check("rst_addr", 32'(read_address), 32'd0);
      tick();
    end

    // Single word: exact latency, then held under back-pressure.
    push_word(8'hA5);
    tick();
    check("single_empty_c1", 32'(read_empty), 32'd0);
    tick();
    check("single_valid_c2", 32'(out_valid), 32'd0);
    tick();
    check("single_valid_c3", 32'(out_valid), 32'd1);
    check("single_data_c3", 32'(out_data), 32'hA5);
    repeat (3) tick();
    check("single_held", 32'(out_data), 32'hA5);
    out_ready = 1'b1;
    tick();
    check("single_popped", 32'(out_valid), 32'd0);
    check("single_empty", 32'(read_empty), 32'd1);
    check("single_ptr", 32'(read_ptr), 32'h01);
    out_ready = 1'b0;

    // Full-memory burst at one word per cycle.
    do_reset();
    for (int i = 0; i < depth; i++) push_word(data_size'(i));
    out_ready = 1'b1;
    tick();
    check("burst_level", 32'(read_level), 32'd16);
    waited = 0;
    @(negedge read_clk);
    while (!out_valid && waited < 20) begin
      @(negedge read_clk);
      waited++;
    end
    for (int i = 0; i < depth; i++) begin
      check("burst_beat", 32'(out_valid), 32'd1);
      @(negedge read_clk);
    end
    check("burst_valid_end", 32'(out_valid), 32'd0);
    check("burst_empty", 32'(read_empty), 32'd1);
    check("burst_ptr", 32'(read_ptr), 32'h18);

    // Back-pressure on 8 queued words, then a 40-word wrapping run.
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(data_size'($urandom));
    run_random(0, 50);
    drain_and_check("bp");
    run_random(40, 60);
    drain_and_check("wrap");

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 8; i++) push_word(data_size'($urandom));
    out_ready = 1'b1;
    waited = 0;
    while (!out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check("midrst_pre_valid", 32'(out_valid), 32'd1);
    @(posedge read_clk);
    #2;
    mon_en     = 1'b0;
    read_rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_empty", 32'(read_empty), 32'd1);
    check("midrst_level", 32'(read_level), 32'd0);
    check("midrst_ptr", 32'(read_ptr), 32'd0);
    check("midrst_data", 32'(out_data), 32'd0);
    write_ptr_sync = '0;
    wbin           = 0;
    consumed       = 0;
    exp_q.delete();
    repeat (2) @(posedge read_clk);
    #1 read_rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (3) begin
      check("post_rst_empty", 32'(read_empty), 32'd1);
      check("post_rst_valid", 32'(out_valid), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
